// File: rtl/ifetch_wide_pkg.sv
// Shared types and constants for the wide instruction fetch stage and its buffer.
package ifetch_wide_pkg;

    localparam int PKG_XLEN = 32;

    // Canonical RISC-V no-op (addi x0, x0, 0) driven on empty decode slots.
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } IFETCH_STATE;

    typedef struct packed {
        logic [31:0]         inst;
        logic [PKG_XLEN-1:0] PC;
        logic [PKG_XLEN-1:0] NPC;
    } IBUF_ENTRY;

    typedef struct packed {
        logic                valid;
        logic [31:0]         inst;
        logic [PKG_XLEN-1:0] PC;
        logic [PKG_XLEN-1:0] NPC;
    } IF_ID_PACKET;

endpackage

// File: rtl/ifetch_wide_if.sv
// Bundle of redirect, I-cache and decode-side signals around the fetch stage.
interface ifetch_wide_if
    import ifetch_wide_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_REDIRECT   = 3,
    parameter int IBUF_DEPTH     = 8,
    parameter int DISPATCH_WIDTH = 2
) ();

    logic [NUM_REDIRECT-1:0]                   redirect_req;
    logic [NUM_REDIRECT-1:0][XLEN-1:0]         redirect_pc;
    logic                                      fetch_stall;
    logic [63:0]                               Icache2proc_data;
    logic                                      Icache2proc_data_valid;
    logic [$clog2(DISPATCH_WIDTH+1)-1:0]       deq_count;
    logic [XLEN-1:0]                           proc2Icache_addr;
    logic                                      proc2Icache_req;
    IF_ID_PACKET [DISPATCH_WIDTH-1:0]          if_packet;
    logic [$clog2(IBUF_DEPTH+1)-1:0]           ibuf_count;
    logic [NUM_REDIRECT-1:0]                   gnt_debug;

    modport master (
        output redirect_req, redirect_pc, fetch_stall,
               Icache2proc_data, Icache2proc_data_valid, deq_count,
        input  proc2Icache_addr, proc2Icache_req, if_packet, ibuf_count, gnt_debug
    );

    modport slave (
        input  redirect_req, redirect_pc, fetch_stall,
               Icache2proc_data, Icache2proc_data_valid, deq_count,
        output proc2Icache_addr, proc2Icache_req, if_packet, ibuf_count, gnt_debug
    );

endinterface

// File: rtl/ifetch_wide_ibuf.sv
// Circular instruction buffer: up to two enqueues and DISPATCH_WIDTH dequeues per cycle,
// with a flush that empties it in one cycle.
module ifetch_wide_ibuf
    import ifetch_wide_pkg::*;
#(
    parameter  int IBUF_DEPTH     = 8,
    parameter  int DISPATCH_WIDTH = 2,
    localparam int PW             = $clog2(IBUF_DEPTH),
    localparam int CW             = $clog2(IBUF_DEPTH + 1),
    localparam int DCW            = $clog2(DISPATCH_WIDTH + 1)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush_i,
    input  logic [1:0]                       enqCount_i,
    input  IBUF_ENTRY [1:0]                  enqEntry_i,
    input  logic [DCW-1:0]                   deqCount_i,
    output IF_ID_PACKET [DISPATCH_WIDTH-1:0] head_o,
    output logic [CW-1:0]                    count_o
);

    IBUF_ENTRY       mem_q [IBUF_DEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   deqEff;

    // Decode may ask for more than is present; only the valid heads leave.
    always_comb begin
        deqEff = (CW'(deqCount_i) > count_q) ? count_q : CW'(deqCount_i);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(deqEff);
            tail_q  <= tail_q + PW'(enqCount_i);
            count_q <= count_q + CW'(enqCount_i) - deqEff;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && !flush_i) begin
            if (enqCount_i != 2'd0) begin
                mem_q[tail_q] <= enqEntry_i[0];
            end
            if (enqCount_i == 2'd2) begin
                mem_q[tail_q + PW'(1)] <= enqEntry_i[1];
            end
        end
    end

    always_comb begin
        head_o = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (CW'(i) < count_q) begin
                head_o[i].valid = 1'b1;
                head_o[i].inst  = mem_q[head_q + PW'(i)].inst;
                head_o[i].PC    = mem_q[head_q + PW'(i)].PC;
                head_o[i].NPC   = mem_q[head_q + PW'(i)].NPC;
            end else begin
                head_o[i].valid = 1'b0;
                head_o[i].inst  = NOP;
                head_o[i].PC    = '0;
                head_o[i].NPC   = '0;
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ifetch_wide.sv
// Wide fetch stage: fixed-priority redirect arbiter, IDLE/FETCH/HOLD request FSM and
// block-to-instruction split feeding the instruction buffer.
module ifetch_wide
    import ifetch_wide_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter int              NUM_REDIRECT   = 3,
    parameter int              IBUF_DEPTH     = 8,
    parameter int              DISPATCH_WIDTH = 2,
    parameter logic [XLEN-1:0] RESET_PC       = '0
) (
    input logic          clock,
    input logic          reset,
    ifetch_wide_if.slave bus
);

    localparam int CW = $clog2(IBUF_DEPTH + 1);

    IFETCH_STATE             state_q;
    logic [XLEN-1:0]         pc_q;
    logic [XLEN-1:0]         pc_d;
    logic [NUM_REDIRECT-1:0] grant;
    logic                    redirect;
    logic [XLEN-1:0]         redirectTarget;
    logic [CW-1:0]           ibufCount;
    logic                    hasRoom;
    logic                    acceptHit;
    logic [1:0]              enqCount;
    IBUF_ENTRY [1:0]         enqEntry;

    // Scan from the lowest-priority source up so the lowest asserted index wins.
    always_comb begin
        grant          = '0;
        redirectTarget = '0;
        for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
            if (bus.redirect_req[i]) begin
                grant          = '0;
                grant[i]       = 1'b1;
                redirectTarget = bus.redirect_pc[i];
            end
        end
    end

    assign redirect = |bus.redirect_req;

    // Room is judged on the pre-dequeue count so a full pair always fits.
    assign hasRoom   = (ibufCount <= CW'(IBUF_DEPTH - 2));
    assign acceptHit = (state_q == FETCH) && bus.Icache2proc_data_valid && !redirect && hasRoom;

    always_comb begin
        enqCount = 2'd0;
        enqEntry = '0;
        pc_d     = pc_q;
        if (acceptHit) begin
            if (!pc_q[2]) begin
                enqCount         = 2'd2;
                enqEntry[0].inst = bus.Icache2proc_data[31:0];
                enqEntry[0].PC   = pc_q;
                enqEntry[0].NPC  = pc_q + XLEN'(4);
                enqEntry[1].inst = bus.Icache2proc_data[63:32];
                enqEntry[1].PC   = pc_q + XLEN'(4);
                enqEntry[1].NPC  = pc_q + XLEN'(8);
                pc_d             = pc_q + XLEN'(8);
            end else begin
                enqCount         = 2'd1;
                enqEntry[0].inst = bus.Icache2proc_data[63:32];
                enqEntry[0].PC   = pc_q;
                enqEntry[0].NPC  = pc_q + XLEN'(4);
                pc_d             = pc_q + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else if (redirect) begin
            state_q <= FETCH;
            pc_q    <= redirectTarget;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                IDLE:    state_q <= FETCH;
                FETCH:   if (bus.fetch_stall || !hasRoom) state_q <= HOLD;
                HOLD:    if (!bus.fetch_stall && hasRoom) state_q <= FETCH;
                default: state_q <= IDLE;
            endcase
        end
    end

    ifetch_wide_ibuf #(
        .IBUF_DEPTH     (IBUF_DEPTH),
        .DISPATCH_WIDTH (DISPATCH_WIDTH)
    ) ibuf (
        .clock      (clock),
        .reset      (reset),
        .flush_i    (redirect),
        .enqCount_i (enqCount),
        .enqEntry_i (enqEntry),
        .deqCount_i (bus.deq_count),
        .head_o     (bus.if_packet),
        .count_o    (ibufCount)
    );

    assign bus.gnt_debug        = grant & {NUM_REDIRECT{reset}};
    assign bus.proc2Icache_req  = (state_q == FETCH);
    assign bus.proc2Icache_addr = {pc_q[XLEN-1:3], 3'b000};
    assign bus.ibuf_count       = ibufCount;

endmodule

// File: doc/ifetch_wide.md
# ifetch_wide

Parametrised next-generation instruction fetch stage. It sits between the redirect sources (EX resolved branch, ROB recovery target, branch predictor) and the I-cache, and feeds decode. It fetches an aligned 64-bit block per I-cache hit, extracts up to two instructions into an instruction buffer of configurable depth, and presents up to `DISPATCH_WIDTH` in-order `IF_ID_PACKET`s per cycle. Redirect sources are arbitrated by fixed priority, and every redirect flushes the buffer.

## Interface
- `XLEN`, 32, address/PC width
- `NUM_REDIRECT`, 3, redirect sources; index 0 has the highest priority (EX, then ROB, then predictor)
- `IBUF_DEPTH`, 8, buffer entries; power of two, at least 4
- `DISPATCH_WIDTH`, 2, packets presented per cycle; at most `IBUF_DEPTH`
- `RESET_PC`, 0, PC after reset

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low; asserted when 0
- `redirect_req`  in  `NUM_REDIRECT`  per-source redirect request
- `redirect_pc`  in  `NUM_REDIRECT`x`XLEN`  per-source target, 4-byte aligned
- `fetch_stall`  in  1  ROB back-pressure; suppresses new I-cache requests
- `Icache2proc_data`  in  64  block at `proc2Icache_addr`
- `Icache2proc_data_valid`  in  1  I-cache hit for the current address
- `deq_count`  in  $clog2(`DISPATCH_WIDTH`+1)  packets decode consumes this cycle
- `proc2Icache_addr`  out  `XLEN`  `{PC[XLEN-1:3],3'b0}`
- `proc2Icache_req`  out  1  request active
- `if_packet`  out  `DISPATCH_WIDTH`x`IF_ID_PACKET`  oldest-first buffer heads
- `ibuf_count`  out  $clog2(`IBUF_DEPTH`+1)  occupied entries
- `gnt_debug`  out  `NUM_REDIRECT`  one-hot redirect grant this cycle

## Operation
- Arbiter: the lowest-index asserted `redirect_req` wins, and `gnt_debug` shows it one-hot. On a grant:
  - PC takes the winner's `redirect_pc`.
  - The buffer is flushed: head, tail and count go to 0.
  - Any I-cache response in that cycle is discarded.
  - `deq_count` is ignored.
  - The FSM goes to FETCH.
- FSM states: IDLE, FETCH, HOLD.
  - IDLE: the first cycle after reset release; `proc2Icache_req`=0. Next state is FETCH.
  - FETCH: `proc2Icache_req`=1. Go to HOLD if `fetch_stall`=1 or free slots (`IBUF_DEPTH`-count) < 2.
  - HOLD: `proc2Icache_req`=0 and responses are ignored. Go to FETCH when `fetch_stall`=0 and free slots ≥ 2.
  - The free-slot check uses the count before the same-cycle dequeue (conservative).
- Hit in FETCH with no redirect:
  - PC[2]=0: enqueue two entries, {PC, data[31:0]} then {PC+4, data[63:32]}; PC advances by 8.
  - PC[2]=1: enqueue one entry, {PC, data[63:32]}; PC advances by 4.
  - Each entry's NPC is its PC+4.
- `proc2Icache_addr` is held stable until a hit or a redirect occurs.
- Output slot i is the entry at head+i. Its `valid` is 1 iff i < count; invalid slots drive `inst`=`NOP` and `PC`=0.
- Dequeue removes min(`deq_count`, valid slots) entries; the excess is clamped silently.
- Pointers wrap modulo `IBUF_DEPTH`. Count can never exceed `IBUF_DEPTH` because of the 2-free-slot rule.

## Timing
- Reset (asynchronous, while `reset`=0): PC=`RESET_PC`, state IDLE, count=0, all `if_packet` slots invalid, `proc2Icache_req`=0, `gnt_debug`=0.
- Reset takes effect immediately mid-operation, including during an outstanding fetch.
- Hit in cycle t: the entries are visible on `if_packet` in cycle t+1.
- Hit-to-decode latency: 1 cycle.
- Redirect granted in cycle t: all slots are invalid in t+1, and `proc2Icache_addr` shows the target in t+1.
- First new instruction after a redirect: cycle t+1+(I-cache latency)+1.
- `gnt_debug` and `proc2Icache_*` are combinational from registered state plus `redirect_req`.

## Structure
- Shared-package additions:
  - `IFETCH_STATE` enum {IDLE, FETCH, HOLD}
  - `IBUF_ENTRY` struct {inst, PC, NPC}
  - `NOP`, reused from sys_defs
- One sub-module, `ifetch_ibuf`: a circular buffer with 0–2 enqueues and 0–`DISPATCH_WIDTH` dequeues per cycle, plus flush. It exposes count and the `DISPATCH_WIDTH` head entries.
- The arbiter and FSM live in the top module.

## Test plan
- Reset release with `RESET_PC`=0 and a 1-cycle-hit I-cache holding insts A at 0x0 and B at 0x4: address 0x0 requested in cycle 2; cycle 3 shows slot0 {0x0,A}, slot1 {0x4,B}, count=2.
- Redirect 0=0x1111_1110, 1=0x2222_2220 and 2=0x3333_3330 all asserted together: `gnt_debug`=001, address becomes 0x1111_1110, buffer empties next cycle. Repeat with only sources 1 and 2: `gnt_debug`=010.
- Redirect to 0x104 (PC[2]=1): one entry {0x104, data[63:32]} enqueued; next address is 0x108.
- Fill with `deq_count`=0 and `IBUF_DEPTH`=8: count reaches 8, `proc2Icache_req`=0 (HOLD). `deq_count`=2 for one cycle: count=6, FETCH resumes the following cycle.
- Redirect in the same cycle as a hit and `deq_count`=2: the response is dropped and count=0 next cycle. `fetch_stall`=1 for 3 cycles: no requests, buffer contents preserved.
- Drive `reset`=0 mid-miss (`data_valid` held low): outputs reset immediately without waiting for a clock edge, and the fetch restarts at `RESET_PC`.
